// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder with IDLE/RUN/DONE control; optional subtract mode under SERIAL_ADD_SUB_EN
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand shift registers, serial sum register and adder carry
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    // Result held for the outside world between operations
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic accept;
    logic carry_init;
    logic a_bit;
    logic b_bit;
    logic ha_p;
    logic ha_g;
    logic cell_s;
    logic cell_c;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_r;
`endif

    assign accept = (state == S_IDLE) && start;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert b into the cell and preset the carry
    assign carry_init = sub;
    assign b_bit      = b_sr[0] ^ sub_r;
`else
    assign carry_init = 1'b0;
    assign b_bit      = b_sr[0];
`endif

    assign a_bit = a_sr[0];

    // Shared 1-bit adder cell: two half adders plus an OR for the carry
    always_comb begin
        ha_p   = a_bit ^ b_bit;
        ha_g   = a_bit & b_bit;
        cell_s = ha_p ^ carry;
        cell_c = ha_g | (ha_p & carry);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Serial datapath: capture on accept, one bit per RUN cycle LSB first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            sum_sr  <= '0;
            carry   <= carry_init;
            bit_cnt <= '0;
        end else if (state == S_RUN) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr  <= {cell_s, sum_sr[WIDTH-1:1]};
            carry   <= cell_c;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

`ifdef SERIAL_ADD_SUB_EN
    // Operation mode is latched with the operands so sub may change afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= sub;
        end
    end
`endif

    // Result hold registers take the finished sum as DONE ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state == S_DONE) begin
            sum_q  <= sum_sr;
            cout_q <= carry;
        end
    end

    // Outputs decode registers only; during DONE the sum register itself is shown
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        sum  = (state == S_DONE) ? sum_sr : sum_q;
        cout = (state == S_DONE) ? carry  : cout_q;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  WIDTH  first operand, captured on accepted start.
REQ-006 SHALL have port op_b  input  WIDTH  second operand, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse: sum/cout valid.
REQ-009 SHALL have port sum  output  WIDTH  result; holds its value until the next accepted start.
REQ-010 SHALL have port cout  output  1  carry out of the MSB; holds like sum.

Function
REQ-011 SHALL compute sum/cout bit-serially with one shared 1-bit adder cell: two half adders plus an OR (s = a^b^c, c' = a&b | c&(a^b)), LSB first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 -> capture op_a/op_b into shift registers, clear carry flop, clear bit counter, clear sum register, go RUN; start=0 -> stay.
REQ-014 RUN: each cycle process the current LSB of both shift registers, shift both right, shift the sum bit into the sum register MSB, update carry flop, increment bit counter.
REQ-015 RUN -> DONE after exactly WIDTH cycles (counter = WIDTH-1 on the last bit); cout takes the final carry.
REQ-016 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-017 Latency: start accepted at edge T -> done high during cycle T+WIDTH+1 -> start accepted again no earlier than the edge ending that DONE cycle +1 (IDLE).
REQ-018 start while busy=1 (RUN or DONE) SHALL be ignored with no effect on state or operands.
REQ-019 Operand inputs SHALL be don't-care except in the cycle start is accepted.
REQ-020 Arithmetic is modulo 2^WIDTH; overflow is reported only via cout; no sign flag.
REQ-021 sum SHALL be driven from the sum register; outputs SHALL have no combinational path from inputs.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, operand registers=0.
REQ-023 Reset mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start is accepted on the first edge with rst_n=1.
REQ-024 start asserted together with rst_n=0 SHALL be ignored.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN: when defined, an extra input port sub (1 bit) SHALL exist, captured with the operands; sub=1 inverts each op_b bit into the adder and presets carry to 1, giving op_a-op_b, where cout=1 means no borrow.
REQ-026 When SERIAL_ADD_SUB_EN is undefined, no sub port SHALL exist and the block SHALL only add (carry preset 0).

Verification (WIDTH=8)
REQ-027 Reset for 2 cycles then release -> busy=0, done=0, sum=0x00, cout=0.
REQ-028 start with op_a=0x0F, op_b=0x01 -> busy high for 9 cycles, done pulse 9 cycles after accept, sum=0x10, cout=0.
REQ-029 op_a=0xFF, op_b=0x01 -> sum=0x00, cout=1; start re-pulsed during RUN -> ignored, result unchanged.
REQ-030 start accepted, rst_n low at the 4th RUN cycle -> no done pulse, all outputs 0; new start op_a=0x55, op_b=0xAA -> sum=0xFF, cout=0.
REQ-031 Back-to-back: start held high continuously -> operations accepted every 10 cycles, sum/cout stable between done pulses.
REQ-032 With SERIAL_ADD_SUB_EN: sub=1, op_a=0x05, op_b=0x07 -> sum=0xFE, cout=0; sub=1, op_a=0x07, op_b=0x05 -> sum=0x02, cout=1.
